bpsk_i_mixer: RTL and testbench



---
 rtl/bpsk_i_mixer.sv | 174 +++++++++++++++++
 tb/tb_bpsk_i_mixer.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/bpsk_i_mixer.sv
// bpsk_i_mixer
//   I-branch BPSK mixer. Buffers serial data bits in a small FIFO, locks
//   symbol timing to the peak of the incoming offset-cosine carrier and, for
//   each symbol, emits either the carrier (bit 1) or its mirror about
//   FULL_SCALE (bit 0). With no bit to send, the idle level MID is emitted.
//
// Ports
//   clk         system clock, one carrier sample per rising edge
//   rst         asynchronous active-high reset
//   carrier_in  unsigned carrier sample from the I carrier generator
//   bit_in      data bit
//   bit_valid   bit_in is valid this cycle
//   bit_ready   FIFO can accept a bit (not full)
//   mod_out     modulated sample, registered, 1 clk after carrier_in
//   mod_valid   mod_out carries data rather than idle
//   locked      symbol timing locked to the carrier
//   underrun    one-cycle pulse at a symbol boundary with an empty FIFO
module bpsk_i_mixer #(
  parameter int DATA_W     = 8,
  parameter int SPS        = 16,
  parameter int PEAK       = 200,
  parameter int FULL_SCALE = 200,
  parameter int MID        = 100,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] carrier_in,
  input  logic              bit_in,
  input  logic              bit_valid,
  output logic              bit_ready,
  output logic [DATA_W-1:0] mod_out,
  output logic              mod_valid,
  output logic              locked,
  output logic              underrun
);

  localparam int CNT_W = $clog2(SPS);
  localparam int PTR_W = $clog2(FIFO_DEPTH);

  localparam logic [DATA_W-1:0] PEAK_V   = DATA_W'(PEAK);
  localparam logic [DATA_W-1:0] FS_V     = DATA_W'(FULL_SCALE);
  localparam logic [DATA_W-1:0] MID_V    = DATA_W'(MID);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(SPS - 1);
  localparam logic [PTR_W:0]    DEPTH_V  = (PTR_W + 1)'(FIFO_DEPTH);

  typedef enum logic {SEARCH, RUN} state_t;

  // Mirror about FULL_SCALE with a 9-bit signed subtract; carrier samples
  // above FULL_SCALE would go negative and are clamped to zero.
  function automatic logic [DATA_W-1:0] mirror_sat(input logic [DATA_W-1:0] x);
    logic signed [DATA_W:0] diff;
    diff = $signed({1'b0, FS_V}) - $signed({1'b0, x});
    if (diff < 0) return '0;
    return diff[DATA_W-1:0];
  endfunction

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               active_q, active_d;
  logic               cur_q, cur_d;
  logic               underrun_d;

  logic               fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]   rd_ptr, wr_ptr;
  logic [PTR_W:0]     count;
  logic               push, pop;

  logic               is_peak, boundary, loss;

  logic [DATA_W-1:0]  mod_p0;
  logic               vld_p0;
  logic [DATA_W-1:0]  mod_p1;
  logic               vld_p1;
  logic               locked_p1;
  logic               underrun_p1;

  assign bit_ready = (count != DEPTH_V);
  assign push      = bit_valid & bit_ready;

  // A symbol starts on the carrier peak: any peak while searching, or the
  // peak expected at sample 0 while running. A missing peak at sample 0
  // means the carrier phase moved under us.
  assign is_peak  = (carrier_in == PEAK_V);
  assign boundary = is_peak & ((state_q == SEARCH) | (cnt_q == '0));
  assign loss     = (state_q == RUN) & (cnt_q == '0) & ~is_peak;

  // ---- stage p0: symbol timing, bit selection, mixing ----
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    active_d   = active_q;
    cur_d      = cur_q;
    underrun_d = 1'b0;
    pop        = 1'b0;

    if (boundary) begin
      if (count != '0) begin
        pop      = 1'b1;
        active_d = 1'b1;
        cur_d    = fifo_mem[rd_ptr];
      end else begin
        active_d   = 1'b0;
        underrun_d = 1'b1;
      end
    end

    if (loss) begin
      state_d  = SEARCH;
      cnt_d    = '0;
      active_d = 1'b0;
    end else if (state_q == RUN) begin
      cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + CNT_W'(1);
    end else if (is_peak) begin
      state_d = RUN;
      cnt_d   = CNT_W'(1);
    end

    // The boundary sample already uses the freshly popped bit.
    if (active_d) mod_p0 = cur_d ? carrier_in : mirror_sat(carrier_in);
    else          mod_p0 = MID_V;
    vld_p0 = active_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= SEARCH;
      cnt_q    <= '0;
      active_q <= 1'b0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      active_q <= active_d;
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + (PTR_W + 1)'(1);
        2'b01:   count <= count - (PTR_W + 1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Bit storage and the current symbol's bit need no reset: active_q gates
  // every use of them.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= bit_in;
    cur_q <= cur_d;
  end

  // ---- stage p1: registered outputs ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mod_p1      <= MID_V;
      vld_p1      <= 1'b0;
      locked_p1   <= 1'b0;
      underrun_p1 <= 1'b0;
    end else begin
      mod_p1      <= mod_p0;
      vld_p1      <= vld_p0;
      locked_p1   <= (state_d == RUN);
      underrun_p1 <= underrun_d;
    end
  end

  assign mod_out   = mod_p1;
  assign mod_valid = vld_p1;
  assign locked    = locked_p1;
  assign underrun  = underrun_p1;

endmodule

// File: tb/tb_bpsk_i_mixer.sv
module tb_bpsk_i_mixer;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] carrier_in = 8'd100;
  logic       bit_in = 1'b0;
  logic       bit_valid = 1'b0;
  logic       bit_ready;
  logic [7:0] mod_out;
  logic       mod_valid;
  logic       locked;
  logic       underrun;

  bpsk_i_mixer dut (
    .clk        (clk),
    .rst        (rst),
    .carrier_in (carrier_in),
    .bit_in     (bit_in),
    .bit_valid  (bit_valid),
    .bit_ready  (bit_ready),
    .mod_out    (mod_out),
    .mod_valid  (mod_valid),
    .locked     (locked),
    .underrun   (underrun)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] mo;
    logic       mv;
    logic       lk;
    logic       ur;
    logic       br;
  } exp_t;

  exp_t exp_q[$];

  // Reference model state: bits waiting, lock flag, position in symbol,
  // whether a bit is being sent and which one.
  bit   m_fifo[$];
  bit   m_run = 0;
  int   m_pos = 0;
  bit   m_act = 0;
  bit   m_cur = 0;

  int   n_cmp = 0;
  int   n_bad = 0;
  int   ph = 0;

  logic [7:0] tbl [16] = '{8'd200, 8'd192, 8'd171, 8'd138, 8'd100, 8'd62, 8'd29, 8'd8,
                           8'd0,   8'd8,   8'd29,  8'd62,  8'd100, 8'd138, 8'd171, 8'd192};

  task automatic chk(input string name, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s: got %0d, required %0d at %0t", name, act, req, $time);
    end
  endtask

  // Apply one cycle of stimulus, predict the outputs after the next edge,
  // and hand the prediction to the monitor once that edge has happened.
  task automatic step(input logic [7:0] c, input logic bv, input logic b);
    exp_t e;
    bit   ready, push, bnd, loss, und;
    int   mix;
    carrier_in = c;
    bit_valid  = bv;
    bit_in     = b;
    if (rst) begin
      m_fifo.delete();
      m_run = 0;
      m_pos = 0;
      m_act = 0;
      e = '{mo: 8'd100, mv: 1'b0, lk: 1'b0, ur: 1'b0, br: 1'b1};
    end else begin
      ready = (m_fifo.size() != 4);
      push  = bv && ready;
      bnd   = (c == 8'd200) && (!m_run || m_pos == 0);
      loss  = m_run && m_pos == 0 && c != 8'd200;
      und   = 0;
      if (bnd) begin
        if (m_fifo.size() > 0) begin
          m_cur = m_fifo.pop_front();
          m_act = 1;
        end else begin
          m_act = 0;
          und   = 1;
        end
      end
      if (push) m_fifo.push_back(b);
      if (loss) begin
        m_run = 0;
        m_pos = 0;
        m_act = 0;
      end else if (m_run) begin
        m_pos = (m_pos + 1) % 16;
      end else if (bnd) begin
        m_run = 1;
        m_pos = 1;
      end
      if (!m_act)     mix = 100;
      else if (m_cur) mix = int'(c);
      else            mix = (int'(c) > 200) ? 0 : 200 - int'(c);
      e.mo = 8'(mix);
      e.mv = m_act;
      e.lk = m_run;
      e.ur = und;
      e.br = (m_fifo.size() != 4);
    end
    @(posedge clk);
    exp_q.push_back(e);
    #1;
  endtask

  // Run n cycles of the carrier with random bits (push_pct), random missing
  // peaks (glitch_pct) and random off-peak sample corruption (inj_pct).
  task automatic run(input int n, input int push_pct, input int glitch_pct, input int inj_pct);
    logic [7:0] c;
    int         v;
    for (int i = 0; i < n; i++) begin
      c = tbl[ph];
      if (ph == 0 && int'($urandom % 100) < glitch_pct) begin
        c = 8'd100;
      end else if (ph != 0 && int'($urandom % 100) < inj_pct) begin
        v = int'($urandom_range(0, 255));
        if (v == 200) v = 255;
        c = 8'(v);
      end
      step(c, int'($urandom % 100) < push_pct, 1'($urandom));
      ph = (ph + 1) % 16;
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("mod_out",   int'(mod_out),   int'(e.mo));
        chk("mod_valid", int'(mod_valid), int'(e.mv));
        chk("locked",    int'(locked),    int'(e.lk));
        chk("underrun",  int'(underrun),  int'(e.ur));
        chk("bit_ready", int'(bit_ready), int'(e.br));
      end
    end
  end

  initial begin : driver
    #1 rst = 1'b1;
    #1;
    chk("rst_mod_out",   int'(mod_out),   100);
    chk("rst_mod_valid", int'(mod_valid), 0);
    chk("rst_locked",    int'(locked),    0);
    chk("rst_underrun",  int'(underrun),  0);
    chk("rst_bit_ready", int'(bit_ready), 1);

    run(3, 0, 0, 0);
    rst = 1'b0;
    run(40, 0, 0, 0);
    run(300, 30, 0, 0);
    run(300, 50, 5, 10);
    run(200, 100, 3, 5);
    run(7, 100, 0, 0);

    // Asynchronous reset partway through a symbol with bits buffered.
    @(negedge clk);
    #1 rst = 1'b1;
    #1;
    chk("arst_mod_out",   int'(mod_out),   100);
    chk("arst_mod_valid", int'(mod_valid), 0);
    chk("arst_locked",    int'(locked),    0);
    chk("arst_bit_ready", int'(bit_ready), 1);
    @(posedge clk);
    #1;
    run(2, 0, 0, 0);
    rst = 1'b0;
    run(48, 0, 0, 0);
    run(300, 40, 2, 5);

    @(negedge clk);
    #1;
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
